prog_timeout_timer: RTL and testbench

PROG_TIMEOUT_TIMER -- requirements
Module: prog_timeout_timer

---
 rtl/prog_timeout_timer.sv | 91 +++++++++
 tb/tb_prog_timeout_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prog_timeout_timer.sv
// prog_timeout_timer: programmable tick-based timeout timer with a prescaler,
// one-shot or auto-reload modes, pause via enable, and abort/restart control.
`default_nettype none

module prog_timeout_timer #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             periodic,
  input  logic [CNT_W-1:0] duration,
  output logic             timeout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] stored_dur;
  logic             stored_per;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      remaining  <= '0;
      stored_dur <= '0;
      stored_per <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start && (duration != '0)) begin
      // A restart discards any pending period, including one expiring now.
      state      <= RUN;
      presc      <= '0;
      remaining  <= duration;
      stored_dur <= duration;
      stored_per <= periodic;
      timeout    <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == RUN && enable) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          if (remaining == ONE) begin
            timeout <= 1'b1;
            if (stored_per) begin
              remaining <= stored_dur;
            end else begin
              remaining <= '0;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            remaining <= remaining - ONE;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_timeout_timer.sv
// tb_prog_timeout_timer: directed and random stimulus checked every cycle
// against an elapsed-cycle reference model of the timer.
`default_nettype none

module tb_prog_timeout_timer;

  localparam int P = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, stop, enable, periodic;
  logic [W-1:0] duration;
  logic         timeout, busy, done;
  logic [W-1:0] remaining;

  int errors = 0;
  int checks = 0;

  // Reference model: counts enabled RUN cycles since the last (re)load.
  int m_run, m_done, m_timeout, m_per, m_dur, m_elapsed;

  prog_timeout_timer #(.PRESCALE(P), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable),
    .periodic(periodic), .duration(duration), .timeout(timeout),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, s, sp, en, pe, input logic [W-1:0] d);
    if (r) begin
      m_run = 0; m_done = 0; m_timeout = 0; m_per = 0; m_dur = 0; m_elapsed = 0;
    end else if (sp) begin
      m_run = 0; m_done = 0; m_timeout = 0; m_elapsed = 0;
    end else if (s && d != 0) begin
      m_run = 1; m_done = 0; m_timeout = 0; m_per = int'(pe); m_dur = int'(d); m_elapsed = 0;
    end else begin
      m_timeout = 0;
      if (m_run == 1 && en) begin
        m_elapsed++;
        if (m_elapsed == m_dur * P) begin
          m_timeout = 1;
          m_elapsed = 0;
          if (m_per == 0) begin
            m_run = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, s, sp, en, pe, input logic [W-1:0] d);
    rst = r; start = s; stop = sp; enable = en; periodic = pe; duration = d;
    @(posedge clk);
    model(r, s, sp, en, pe, d);
    #1;
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("remaining", 32'(remaining), (m_run == 1) ? 32'(m_dur - m_elapsed / P) : 32'd0);
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, en, 1'b0, 8'd0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; periodic = 1'b0; duration = '0;
    m_run = 0; m_done = 0; m_timeout = 0; m_per = 0; m_dur = 0; m_elapsed = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd7);
    chk("reset_busy", 32'(busy), 32'd0);

    // One-shot, duration 3: pulse exactly 12 cycles after the start edge
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    run(11, 1'b1);
    chk("oneshot_early", 32'(timeout), 32'd0);
    run(1, 1'b1);
    chk("oneshot_pulse", 32'(timeout), 32'd1);
    chk("oneshot_done", 32'(done), 32'd1);
    chk("oneshot_rem", 32'(remaining), 32'd0);
    run(3, 1'b1);
    chk("done_sticky", 32'(done), 32'd1);

    // Periodic, duration 2: a pulse every 8 cycles
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      run(1, 1'b1);
      if (timeout) pulses++;
      if (i % 8 == 0) chk("periodic_pulse", 32'(timeout), 32'd1);
    end
    chk("periodic_count", 32'(pulses), 32'd4);
    chk("periodic_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

    // Pause: duration 2, enable low 5 cycles -> pulse at 13
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    run(3, 1'b1);
    run(5, 1'b0);
    chk("pause_hold", 32'(remaining), 32'd2);
    run(4, 1'b1);
    chk("pause_early", 32'(timeout), 32'd0);
    run(1, 1'b1);
    chk("pause_pulse", 32'(timeout), 32'd1);

    // Restart after 6 cycles with duration 1 -> pulse 4 cycles later
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    run(5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    chk("restart_rem", 32'(remaining), 32'd1);
    run(4, 1'b1);
    chk("restart_pulse", 32'(timeout), 32'd1);

    // Abort at remaining = 1
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    run(4, 1'b1);
    chk("abort_rem", 32'(remaining), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    run(8, 1'b1);
    chk("abort_idle", 32'(busy), 32'd0);

    // Corners: zero-duration start, start+stop, start on expiry cycle
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    chk("zero_dur", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
    chk("start_stop", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    run(7, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    chk("start_expiry_to", 32'(timeout), 32'd0);
    chk("start_expiry_rem", 32'(remaining), 32'd3);

    // Reset mid-run at remaining = 2
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    run(4, 1'b1);
    chk("midrun_rem", 32'(remaining), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    run(12, 1'b1);
    chk("midrun_after", 32'(timeout), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 5) != 0),
           1'($urandom),
           8'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
